// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined LEGv8 CPU: datapath widths, the NOP
// encoding and the IF/ID payload that later stages reuse.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;
  localparam logic [ADDR_W-1:0]  PC_INC    = 64'd4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  // A bubble looks like a NOP fetched from address 0.
  localparam if_id_t IF_ID_BUBBLE = '{
    pc:       '0,
    pc_plus4: PC_INC,
    instr:    NOP_INSTR,
    valid:    1'b0
  };

  function automatic if_id_t make_if_id(input logic [ADDR_W-1:0]  pc,
                                        input logic [INSTR_W-1:0] instr);
    if_id_t p;
    p.pc       = pc;
    p.pc_plus4 = pc + PC_INC;
    p.instr    = instr;
    p.valid    = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with load enable and synchronous clear to a
// constant; clear takes priority over the enable.
module pipe_reg #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      q_reg <= CLR_VAL;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures PC, PC+4 and the fetched instruction,
// with hazard stall, branch flush and a saturating bubble counter.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall,
  input  logic               flush,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
  output logic [CNT_W-1:0]   bubble_cnt
);

  if_id_t           slot_next;
  if_id_t           slot_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  assign slot_next = make_if_id(pc_in, instr_in);

  // Reset and flush both clear to the bubble value, which already carries
  // NOP_INSTR, so instr_out needs no output mux.
  pipe_reg #(
    .WIDTH   ($bits(if_id_t)),
    .CLR_VAL (IF_ID_BUBBLE)
  ) u_payload (
    .clk (clk),
    .en  (!stall),
    .clr (reset || flush),
    .d   (slot_next),
    .q   (slot_reg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_reg <= '0;
    end else if (flush && (bubble_cnt_reg != '1)) begin
      bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign pc_out       = slot_reg.pc;
  assign pc_plus4_out = slot_reg.pc_plus4;
  assign instr_out    = slot_reg.instr;
  assign valid_out    = slot_reg.valid;
  assign bubble_cnt   = bubble_cnt_reg;

endmodule
